reg_rr_arbiter: RTL
===================

Name: reg_rr_arbiter

Overview:
- N-to-1 arbiter for the register interface (req: addr/write/wdata/wstrb/valid; rsp: rdata/error/ready).
- Shares one register-file target, such as a regtool-generated register file behind the empty-write filter, between several requesters, for example a debug module, a core and a DMA config port.
- Uses a registered round-robin grant held for a whole transaction, plus an optional per-transaction timeout that completes a hung access with an error.

Parameters:
NumPorts, 2, number of requesters; must be >= 2.
TimeoutCycles, 0, BUSY cycles before abort; 0 disables timeout. Counter width is $clog2(TimeoutCycles+1).
req_t, logic, register-interface request struct.
rsp_t, logic, register-interface response struct.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
in_req_i  in  NumPorts x req_t  requester requests
in_rsp_o  out  NumPorts x rsp_t  requester responses
out_req_o  out  req_t  request to shared target
out_rsp_i  in  rsp_t  response from shared target
busy_o  out  1  state is BUSY
grant_idx_o  out  $clog2(NumPorts)  index of the current/last grant
timeout_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- All state is clocked on clk_i with synchronous active-high reset. No logic is sensitive to the reset edge.
- State values: state=IDLE, grant_q=0, prio_q=0, cnt_q=0.
- Reset values of outputs: out_req_o all-zero (valid=0), every in_rsp_o all-zero (ready=0), busy_o=0, grant_idx_o=0, timeout_o=0.
- IDLE state:
  - out_req_o.valid=0. All in_rsp_o are zero.
  - If any in_req_i[i].valid: pick the first valid index starting at prio_q, wrapping modulo NumPorts.
  - Latch the pick into grant_q, clear cnt_q, move to BUSY.
  - This is a one-cycle arbitration bubble: the minimum transaction is 2 cycles from valid to ready.
- BUSY state:
  - out_req_o = in_req_i[grant_q], all fields passed through combinationally.
  - in_rsp_o[grant_q] = out_rsp_i. All other in_rsp_o = '0.
- BUSY completion: out_req_o.valid && out_rsp_i.ready → next state IDLE, prio_q = (grant_q+1) mod NumPorts. The requester sees ready in this same cycle.
- BUSY timeout:
  - Condition: TimeoutCycles != 0, cnt_q == TimeoutCycles-1, and out_rsp_i.ready=0.
  - Then out_req_o.valid forced to 0, and in_rsp_o[grant_q] = {ready=1, error=1, rdata='0}.
  - timeout_o=1 for this cycle. Next state IDLE, prio_q advances as on completion.
  - If ready and timeout coincide, the real response wins and there is no timeout pulse.
- BUSY counting: otherwise cnt_q increments, saturating at TimeoutCycles-1.
- Protocol violation: if in_req_i[grant_q].valid drops while BUSY, out_req_o.valid drops with it, and state returns to IDLE next cycle without a response. prio_q is not advanced.
- Fixed request: the granted request must not change while BUSY. This is a requester obligation; the arbiter does not re-sample it.
- Fairness: after a port completes, it has lowest priority. Under continuous requests from k ports, each port is served once per k transactions.
- Reset mid-transaction: returns to IDLE next cycle with out valid=0. Any outstanding target access is abandoned; the target must tolerate valid dropping.
- busy_o = (state==BUSY).
- grant_idx_o = grant_q; it holds its last value in IDLE.

Decomposition:
- Package reg_arb_pkg: state enum (IDLE, BUSY) and an idx width helper function.
- Sub-module reg_rr_pick:
  - Combinational: valid vector plus prio pointer → pick index and any_valid.
  - Implemented as a rotate, a leading-one search, then an un-rotate.
  - Reusable by other interconnect arbiters.

Test Plan:
- Single requester, NumPorts=3: port1 read addr 0x10; target ready on its 1st BUSY cycle, rdata 0xCAFE → port1 ready at cycle 2 with rdata 0xCAFE, in_rsp_o[0] and in_rsp_o[2] stay 0, prio_q=2.
- All 3 ports hold valid continuously after reset → grant order 0,1,2,0,1,2. Each grant_idx_o value is seen once per 3 transactions, with an IDLE cycle between transactions.
- TimeoutCycles=4, target never ready → exactly 4 BUSY cycles, then port0 gets ready=1, error=1, timeout_o pulse, and out valid=0 in that cycle.
- TimeoutCycles=4, ready arrives in the 4th BUSY cycle → normal completion with error from the target (0), and timeout_o=0.
- rst_i asserted in the 2nd BUSY cycle → next cycle IDLE, out valid=0, grant_idx_o=0, and arbitration restarts from port0.
- Granted port drops valid mid-BUSY → out valid drops the same cycle, state returns to IDLE, and prio_q is unchanged.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and width helpers for the register-interface round-robin arbiter.
package reg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/reg_rr_pick.sv
// Round-robin pick: first set bit of a valid vector at or after a priority pointer.
module reg_rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned IdxW     = idx_width(NumPorts)
) (
  input  logic [NumPorts-1:0] i_valid,
  input  logic [IdxW-1:0]     i_prio,
  output logic [IdxW-1:0]     o_pick,
  output logic                o_any
);

  localparam logic [IdxW:0] NumPortsW = (IdxW+1)'(NumPorts);

  logic [2*NumPorts-1:0] w_dbl;
  logic [NumPorts-1:0]   w_rot;
  logic [IdxW-1:0]       w_off;
  logic [IdxW:0]         w_sum;

  // Rotate so the priority port lands at bit 0, then the lowest set bit wins.
  always_comb begin
    w_dbl = {i_valid, i_valid};
    w_rot = NumPorts'(w_dbl >> i_prio);
    w_off = '0;
    for (int j = NumPorts - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = IdxW'(j);
    end
    w_sum  = {1'b0, w_off} + {1'b0, i_prio};
    o_pick = (w_sum >= NumPortsW) ? IdxW'(w_sum - NumPortsW) : w_sum[IdxW-1:0];
    o_any  = |i_valid;
  end

endmodule

// File: rtl/reg_rr_arbiter.sv
// N-to-1 register-interface arbiter: registered round-robin grant held for a
// whole transaction, with an optional timeout that completes a hung access.
module reg_rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         req_t         = reg_req_t,
  parameter type         rsp_t         = reg_rsp_t
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  req_t                             in_req_i [NumPorts],
  output rsp_t                             in_rsp_o [NumPorts],
  output req_t                             out_req_o,
  input  rsp_t                             out_rsp_i,
  output logic                             busy_o,
  output logic [idx_width(NumPorts)-1:0]   grant_idx_o,
  output logic                             timeout_o
);

  localparam int unsigned   IdxW   = idx_width(NumPorts);
  localparam int unsigned   CntW   = cnt_width(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax =
    (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPorts - 1);

  arb_state_e          r_state;
  logic [IdxW-1:0]     r_grant;
  logic [IdxW-1:0]     r_prio;
  logic [CntW-1:0]     r_cnt;

  logic [NumPorts-1:0] w_valid;
  logic [IdxW-1:0]     w_pick;
  logic                w_any;
  logic                w_busy;
  logic                w_gnt_valid;
  logic                w_done;
  logic                w_timeout;
  logic                w_drop;
  logic [IdxW-1:0]     w_next_prio;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NumPorts; i++) w_valid[i] = in_req_i[i].valid;
  end

  reg_rr_pick #(
    .NumPorts (NumPorts),
    .IdxW     (IdxW)
  ) u_pick (
    .i_valid (w_valid),
    .i_prio  (r_prio),
    .o_pick  (w_pick),
    .o_any   (w_any)
  );

  assign w_busy      = (r_state == BUSY);
  assign w_gnt_valid = in_req_i[r_grant].valid;
  assign w_drop      = w_busy && !w_gnt_valid;
  assign w_done      = w_busy && w_gnt_valid && out_rsp_i.ready;
  // A real response arriving on the last allowed cycle beats the abort.
  assign w_timeout   = (TimeoutCycles != 0) && w_busy && w_gnt_valid &&
                       (r_cnt == CntMax) && !out_rsp_i.ready;
  assign w_next_prio = (r_grant == LastIdx) ? '0 : r_grant + 1'b1;

  always_comb begin
    out_req_o = '0;
    for (int i = 0; i < NumPorts; i++) in_rsp_o[i] = '0;
    if (w_busy) begin
      out_req_o = in_req_i[r_grant];
      in_rsp_o[r_grant] = out_rsp_i;
      if (w_timeout) begin
        out_req_o.valid         = 1'b0;
        in_rsp_o[r_grant]       = '0;
        in_rsp_o[r_grant].ready = 1'b1;
        in_rsp_o[r_grant].error = 1'b1;
      end
    end
  end

  assign busy_o      = w_busy;
  assign grant_idx_o = r_grant;
  assign timeout_o   = w_timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_prio  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_drop) begin
            // Requester abandoned the access: no response, priority untouched.
            r_state <= IDLE;
          end else if (w_done || w_timeout) begin
            r_state <= IDLE;
            r_prio  <= w_next_prio;
          end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
